// File: rtl/gmii_rx_sfd_framer_if.sv
// Byte-stream bus between the GMII RX framer and the RX MAC/CRC stage.
// Handshake: a beat transfers on every clock edge where tvalid=1. There is
// no tready; the stream runs at line rate and the sink must always accept.
// tlast marks the final byte of a frame, and tuser (meaningful only with
// tlast) flags the frame as bad. tdata holds its last value while tvalid=0.
interface gmii_rx_sfd_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface

// File: rtl/gmii_rx_sfd_framer.sv
// GMII RX preamble/SFD stripper. It converts registered rx_dv/rx_er framing
// into a byte stream with tlast/tuser. A one-byte hold register delays the
// payload by one beat, so the final byte can be tagged with tlast when
// rx_dv falls.
// Optional statistics counters: define GMII_RX_FRAMER_STATS_EN.
module gmii_rx_sfd_framer #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MAX_PREAMBLE = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            gmii_rxd,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  gmii_rx_sfd_framer_if.master  m_axis,
  output logic                  status_preamble_err,
  output logic                  status_frame_done,
  output logic [CNT_WIDTH-1:0]  stat_frames_good,
  output logic [CNT_WIDTH-1:0]  stat_frames_bad,
  output logic [CNT_WIDTH-1:0]  stat_preamble_err,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(MAX_PREAMBLE + 2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    hold;
  logic          hold_valid;
  logic          err_flag;
  logic          dv_prev;

  assign dbg_state = state;

  // Framing FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      pre_cnt             <= '0;
      hold                <= 8'h00;
      hold_valid          <= 1'b0;
      err_flag            <= 1'b0;
      dv_prev             <= 1'b1;  // ignore a frame already in flight
      m_axis.tdata        <= 8'h00;
      m_axis.tvalid       <= 1'b0;
      m_axis.tlast        <= 1'b0;
      m_axis.tuser        <= 1'b0;
      status_preamble_err <= 1'b0;
      status_frame_done   <= 1'b0;
    end else begin
      dv_prev             <= gmii_rx_dv;
      m_axis.tvalid       <= 1'b0;
      m_axis.tlast        <= 1'b0;
      m_axis.tuser        <= 1'b0;
      status_preamble_err <= 1'b0;
      status_frame_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Only a rising rx_dv may open a frame; rx_er alone is ignored.
          if (gmii_rx_dv && !dv_prev) begin
            if (gmii_rxd == 8'h55) begin
              state   <= S_PREAMBLE;
              pre_cnt <= PW'(1);
            end else if (gmii_rxd == 8'hD5 && MIN_PREAMBLE == 0) begin
              state      <= S_PAYLOAD;
              err_flag   <= 1'b0;
              hold_valid <= 1'b0;
            end else begin
              state               <= S_DROP;
              status_preamble_err <= 1'b1;
            end
          end
        end
        S_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state               <= S_IDLE;
            status_preamble_err <= 1'b1;
          end else if (gmii_rx_er) begin
            state               <= S_DROP;
            status_preamble_err <= 1'b1;
          end else if (gmii_rxd == 8'h55) begin
            // Saturate one past the limit so an over-long preamble is caught at SFD.
            if (int'(pre_cnt) <= MAX_PREAMBLE) pre_cnt <= pre_cnt + 1'b1;
          end else if (gmii_rxd == 8'hD5 && int'(pre_cnt) >= MIN_PREAMBLE &&
                       int'(pre_cnt) <= MAX_PREAMBLE) begin
            state      <= S_PAYLOAD;
            err_flag   <= 1'b0;
            hold_valid <= 1'b0;
          end else begin
            state               <= S_DROP;
            status_preamble_err <= 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (gmii_rx_dv) begin
            hold       <= gmii_rxd;
            hold_valid <= 1'b1;
            if (gmii_rx_er) err_flag <= 1'b1;
            if (hold_valid) begin
              m_axis.tdata  <= hold;
              m_axis.tvalid <= 1'b1;
            end
          end else begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            if (hold_valid) begin
              m_axis.tdata      <= hold;
              m_axis.tvalid     <= 1'b1;
              m_axis.tlast      <= 1'b1;
              m_axis.tuser      <= err_flag;
              status_frame_done <= 1'b1;
            end else begin
              // SFD followed directly by dv low: nothing to deliver.
              status_preamble_err <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!gmii_rx_dv) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GMII_RX_FRAMER_STATS_EN
  // Saturating frame/error counters driven from the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_good  <= '0;
      stat_frames_bad   <= '0;
      stat_preamble_err <= '0;
    end else begin
      if (m_axis.tvalid && m_axis.tlast && !m_axis.tuser && stat_frames_good != '1)
        stat_frames_good <= stat_frames_good + 1'b1;
      if (m_axis.tvalid && m_axis.tlast && m_axis.tuser && stat_frames_bad != '1)
        stat_frames_bad <= stat_frames_bad + 1'b1;
      if (status_preamble_err && stat_preamble_err != '1)
        stat_preamble_err <= stat_preamble_err + 1'b1;
    end
  end
`else
  assign stat_frames_good  = '0;
  assign stat_frames_bad   = '0;
  assign stat_preamble_err = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_sfd_framer.sv
// Directed bench for gmii_rx_sfd_framer. A frame-level model turns each
// transmitted byte list into expected beats; a compare thread checks every
// output beat against that queue.
module tb_gmii_rx_sfd_framer;
  localparam int MIN_PRE = 1;
  localparam int MAX_PRE = 15;

  logic        clk;
  logic        rst;
  logic [7:0]  rxd;
  logic        dv;
  logic        er;
  logic        perr;
  logic        fdone;
  logic [31:0] s_good;
  logic [31:0] s_bad;
  logic [31:0] s_perr;
  logic [1:0]  dbg_state;

  gmii_rx_sfd_framer_if m_axis ();

  gmii_rx_sfd_framer #(
    .MIN_PREAMBLE (MIN_PRE),
    .MAX_PREAMBLE (MAX_PRE),
    .CNT_WIDTH    (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .gmii_rxd            (rxd),
    .gmii_rx_dv          (dv),
    .gmii_rx_er          (er),
    .m_axis              (m_axis.master),
    .status_preamble_err (perr),
    .status_frame_done   (fdone),
    .stat_frames_good    (s_good),
    .stat_frames_bad     (s_bad),
    .stat_preamble_err   (s_perr),
    .dbg_state           (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_fail;
  logic [9:0] exp_q[$];
  logic [7:0] fb[$];
  logic       fe[$];
  int         exp_perr;
  int         perr_at_rst;
  int         act_perr;
  int         exp_good;
  int         exp_bad;
  int         beats;
  int         lasts;
  int         base_b;
  int         base_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dv  = 1'b0;
    er  = 1'b0;
    rxd = 8'h00;
    repeat (n) tick();
  endtask

  // Build a frame: npre x 0x55, sfd, then npay bytes base+1.. with rx_er on one.
  task automatic build(input int npre, input logic [7:0] sfd, input int npay,
                       input logic [7:0] base, input int er_idx);
    fb.delete();
    fe.delete();
    for (int k = 0; k < npre; k++) begin
      fb.push_back(8'h55);
      fe.push_back(1'b0);
    end
    fb.push_back(sfd);
    fe.push_back(1'b0);
    for (int k = 1; k <= npay; k++) begin
      fb.push_back(base + 8'(k));
      fe.push_back(k == er_idx);
    end
  endtask

  // Frame-level model: accept iff the preamble count is in range, the next
  // byte is a clean SFD and at least one payload byte follows.
  task automatic model_frame();
    int   n;
    int   i;
    logic ok;
    logic bad_er;
    logic tu;
    logic is_last;
    n = 0;
    i = 0;
    bad_er = 1'b0;
    while (i < fb.size() && fb[i] == 8'h55) begin
      if (i > 0 && fe[i]) bad_er = 1'b1;
      n++;
      i++;
    end
    ok = (i < fb.size()) && (fb[i] == 8'hD5) && (n >= MIN_PRE) && (n <= MAX_PRE) &&
         !bad_er && !(i > 0 && fe[i]);
    if (!ok || i + 1 >= fb.size()) begin
      exp_perr++;
    end else begin
      tu = 1'b0;
      for (int k = i + 1; k < fb.size(); k++) tu |= fe[k];
      for (int k = i + 1; k < fb.size(); k++) begin
        is_last = (k == fb.size() - 1);
        exp_q.push_back({fb[k], is_last, is_last & tu});
      end
      if (tu) exp_bad++;
      else    exp_good++;
    end
  endtask

  task automatic drive_frame();
    for (int k = 0; k < fb.size(); k++) begin
      dv  = 1'b1;
      rxd = fb[k];
      er  = fe[k];
      tick();
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef GMII_RX_FRAMER_STATS_EN
    check({tag, "_stat_good"}, s_good, 32'(exp_good));
    check({tag, "_stat_bad"},  s_bad,  32'(exp_bad));
    check({tag, "_stat_perr"}, s_perr, 32'(exp_perr - perr_at_rst));
`else
    check({tag, "_stat_good"}, s_good, 32'd0);
    check({tag, "_stat_bad"},  s_bad,  32'd0);
    check({tag, "_stat_perr"}, s_perr, 32'd0);
`endif
  endtask

  initial begin
    logic [9:0] e;
    n_checks = 0; n_fail = 0;
    exp_perr = 0; perr_at_rst = 0; act_perr = 0;
    exp_good = 0; exp_bad = 0; beats = 0; lasts = 0;

    // Compare thread: every output beat against the expected queue.
    fork
      forever begin
        @(negedge clk);
        if (perr === 1'b1) act_perr++;
        if (m_axis.tvalid === 1'b1 || fdone === 1'b1)
          check("frame_done_vs_tlast", 32'(fdone), 32'(m_axis.tvalid & m_axis.tlast));
        if (m_axis.tvalid === 1'b1) begin
          beats++;
          if (m_axis.tlast === 1'b1) lasts++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat_q_size", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("beat", {22'd0, m_axis.tdata, m_axis.tlast, m_axis.tuser}, {22'd0, e});
          end
        end
      end
    join_none

    // Reset.
    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00;
    tick(); tick(); tick();
    check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_tlast",  32'(m_axis.tlast),  32'd0);
    check("rst_tdata",  32'(m_axis.tdata),  32'd0);
    check("rst_perr",   32'(perr),          32'd0);
    check("rst_fdone",  32'(fdone),         32'd0);
    check_stats("rst");
    rst = 1'b0;
    idle(2);

    // T1: clean 64-byte frame.
    base_b = beats; base_l = lasts;
    build(7, 8'hD5, 64, 8'h00, 0);
    model_frame();
    check("t1_model_q_size", 32'(exp_q.size()), 32'd64);
    drive_frame();
    idle(3);
    check("t1_beats", 32'(beats - base_b), 32'd64);
    check("t1_lasts", 32'(lasts - base_l), 32'd1);
    check_stats("t1");

    // T2: same frame with rx_er on payload byte 10.
    base_b = beats; base_l = lasts;
    build(7, 8'hD5, 64, 8'h00, 10);
    model_frame();
    check("t2_model_tail", 32'(exp_q[63]), 32'h103);
    drive_frame();
    idle(3);
    check("t2_beats", 32'(beats - base_b), 32'd64);
    check_stats("t2");

    // T3: bad SFD byte, DROP until dv low, then one idle cycle and a good frame.
    base_b = beats; base_l = lasts;
    fb.delete(); fe.delete();
    fb = '{8'h55, 8'h55, 8'hAA, 8'h55, 8'h55};
    fe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    model_frame();
    drive_frame();
    idle(1);
    check("t3_perr_pulses", 32'(act_perr), 32'd1);
    build(7, 8'hD5, 4, 8'h20, 0);
    model_frame();
    drive_frame();
    idle(3);
    check("t3_beats", 32'(beats - base_b), 32'd4);
    check_stats("t3");

    // T4: 16-byte preamble exceeds the limit.
    base_b = beats;
    build(16, 8'hD5, 4, 8'h30, 0);
    model_frame();
    drive_frame();
    idle(3);
    check("t4_beats", 32'(beats - base_b), 32'd0);
    check("t4_perr_pulses", 32'(act_perr), 32'd2);
    check_stats("t4");

    // T5: two 4-byte frames with exactly one dv-low cycle between.
    base_b = beats; base_l = lasts;
    build(7, 8'hD5, 4, 8'h40, 0);
    model_frame();
    drive_frame();
    idle(1);
    build(7, 8'hD5, 4, 8'h50, 0);
    model_frame();
    drive_frame();
    idle(3);
    check("t5_beats", 32'(beats - base_b), 32'd8);
    check("t5_lasts", 32'(lasts - base_l), 32'd2);
    check_stats("t5");

    // T6: one-cycle reset on payload byte 20; bytes 1..18 were already delivered.
    base_b = beats; base_l = lasts;
    build(7, 8'hD5, 40, 8'h00, 0);
    for (int j = 1; j <= 18; j++) exp_q.push_back({8'(j), 2'b00});
    for (int k = 0; k < fb.size(); k++) begin
      dv  = 1'b1;
      rxd = fb[k];
      er  = fe[k];
      rst = (k == 27);
      tick();
      if (k == 27) begin
        check("t6_rst_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("t6_rst_tdata",  32'(m_axis.tdata),  32'd0);
        exp_good = 0; exp_bad = 0; perr_at_rst = exp_perr;
      end
    end
    rst = 1'b0;
    idle(1);
    build(7, 8'hD5, 4, 8'h60, 0);
    model_frame();
    drive_frame();
    idle(3);
    check("t6_beats", 32'(beats - base_b), 32'd22);
    check("t6_lasts", 32'(lasts - base_l), 32'd1);
    check_stats("t6");

    // Final accounting.
    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("end_perr_pulses", 32'(act_perr), 32'(exp_perr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
